i2c_bit_ctrl: RTL
=================

Name: i2c_bit_ctrl

Overview:
- I2C bit-level engine. It sits directly downstream of the I2C clock divider and consumes its output as a single-cycle tick enable at 4x the SCL rate.
- It executes one bus primitive per command (START, STOP, WRITE bit, READ bit) by sequencing the open-drain SCL/SDA enables over 4 quarter-period phases.
- It honours clock stretching and detects arbitration loss. The byte-level controller sits upstream and issues commands over a valid/ready handshake.

Parameters:
- SYNC_STAGES, 2, flop depth of the scl_i/sda_i input synchronizers (>=2).

Ports:
- clk_i  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- tick_i  in  1  one-cycle pulse at 4x SCL rate, from the clock divider.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle, command accepted this cycle if cmd_valid.
- cmd  in  2  0=START, 1=STOP, 2=WRITE, 3=READ.
- cmd_din  in  1  bit to transmit for WRITE; ignored otherwise.
- done  out  1  one-cycle pulse, command completed.
- dout  out  1  bit sampled by the last READ.
- arb_lost  out  1  one-cycle pulse, arbitration lost.
- busy  out  1  command in progress.
- scl_i  in  1  SCL pad level.
- sda_i  in  1  SDA pad level.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (port reset).
- Reset values: scl_oe=0, sda_oe=0, cmd_ready=1, done=0, dout=0, arb_lost=0, busy=0, state IDLE, phase 0. Reset mid-command aborts immediately, releases both lines and pulses neither done nor arb_lost.
- States: IDLE, RUN (phase counter P0..P3).
- Handshake: cmd_ready = (state==IDLE). Accept on cmd_valid & cmd_ready; latch cmd and cmd_din, enter RUN at P0.
- All outputs are registered. P0 line values appear the cycle after accept.
- A tick_i in the accept cycle is not counted. Ticks in IDLE are ignored.
- Phase advance: in RUN, each tick_i moves Pn to Pn+1. The tick leaving P3 returns to IDLE and pulses done the next cycle.
- Nominal latency is 4 counted ticks plus 1 cycle.
- Line drive per phase, written as (scl_oe, sda_oe):
  - START: P0 (0,0); P1 (0,0); P2 (0,1); P3 (1,1).
  - STOP: P0 (1,1); P1 (0,1); P2 (0,1); P3 (0,0).
  - WRITE: SCL P0 1, P1 0, P2 0, P3 1; sda_oe = ~cmd_din for all phases.
  - READ: SCL as for WRITE; sda_oe=0 for all phases.
- IDLE holds the last P3 line values. After WRITE/READ/START, SCL stays low; after STOP, the bus is released.
- Clock stretching: in any phase where scl_oe=0, a tick_i is discarded while the synchronized scl_i==0. There is no timeout.
- READ sampling: dout <= synchronized sda_i on the tick leaving P2. dout holds until the next READ.
- Arbitration: during WRITE with cmd_din=1 in P1 or P2, synchronized sda_i==0 triggers the following, and done is not pulsed:
  - arb_lost pulses for 1 cycle.
  - scl_oe and sda_oe are forced to 0.
  - state goes to IDLE.
- busy = (state==RUN).
- scl_i/sda_i pass through SYNC_STAGES flops before any use.

Decomposition:
- Package i2c_pkg:
  - command encodings CMD_START/STOP/WRITE/READ.
  - phase width, with constants P0..P3.
  - state encoding IDLE/RUN.
- Sub-module i2c_sync (parameterized N-flop synchronizer, reset value 1), instantiated for scl_i and sda_i.

Test Plan:
- Reset, then START with tick every 10 cycles, scl_i/sda_i following the outputs -> (scl_oe,sda_oe) sequence (0,0),(0,0),(0,1),(1,1); done pulses 1 cycle after the 4th tick; cmd_ready returns to 1.
- WRITE cmd_din=0, then STOP -> sda_oe=1 for all WRITE phases, SCL pattern 1,0,0,1; after STOP both oe=0, busy=0.
- READ with sda_i=0 during P2 -> dout=0. Repeat with sda_i=1 -> dout=1; sda_oe stays 0 throughout.
- WRITE with scl_i held low for 50 cycles in P1 -> ticks in that window are discarded; P1 is exited only on the first tick after scl_i rises; done is delayed accordingly.
- WRITE cmd_din=1 with sda_i forced 0 in P1 -> arb_lost pulses 1 cycle; both oe=0; no done; cmd_ready=1.
- reset asserted in P2 of READ; cmd_valid with tick in the same cycle as accept -> reset yields all outputs at reset values next cycle. The coincident tick is not counted: 4 further ticks are needed before done.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared encodings and the per-phase line-drive table for the I2C bit engine
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int PHASE_W = 2;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t P0 = 2'd0;
    localparam phase_t P1 = 2'd1;
    localparam phase_t P2 = 2'd2;
    localparam phase_t P3 = 2'd3;

    // Returns {scl_oe, sda_oe} for a command in a given quarter-period phase.
    // WRITE/READ share the SCL low-high-high-low... pattern seen as oe 1,0,0,1.
    function automatic logic [1:0] line_drive(cmd_e c, phase_t p, logic din);
        return c == CMD_START ? {p == P3, p >= P2} :
               c == CMD_STOP  ? {p == P0, p != P3} :
                                {p == P0 || p == P3, c == CMD_WRITE && !din};
    endfunction

endpackage

// File: rtl/i2c_bit_ctrl_if.sv
// i2c_bit_ctrl_if: command handshake, tick and pad signals of the I2C bit engine
//   master: upstream controller / pad model (drives tick_i, cmd_*, scl_i, sda_i)
//   slave : the bit engine (drives cmd_ready, done, dout, arb_lost, busy, scl_oe, sda_oe)
interface i2c_bit_ctrl_if;
    import i2c_pkg::*;

    logic tick_i;
    logic cmd_valid;
    logic cmd_ready;
    cmd_e cmd;
    logic cmd_din;
    logic done;
    logic dout;
    logic arb_lost;
    logic busy;
    logic scl_i;
    logic sda_i;
    logic scl_oe;
    logic sda_oe;

    modport master (
        output tick_i, cmd_valid, cmd, cmd_din, scl_i, sda_i,
        input  cmd_ready, done, dout, arb_lost, busy, scl_oe, sda_oe
    );

    modport slave (
        input  tick_i, cmd_valid, cmd, cmd_din, scl_i, sda_i,
        output cmd_ready, done, dout, arb_lost, busy, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_sync.sv
// i2c_sync: N-flop synchronizer for an asynchronous pad level, resets to 1 (idle bus level)
//   clk_i, reset : clock and synchronous active-high reset
//   d            : asynchronous input
//   q            : synchronized output
module i2c_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk_i) begin
        if (reset) ff <= '1;
        else       ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/i2c_bit_ctrl.sv
// i2c_bit_ctrl: I2C bit engine executing START/STOP/WRITE/READ over four tick-paced phases
//   clk_i, reset : clock and synchronous active-high reset
//   bus          : command handshake, tick enable, status pulses and open-drain pad signals
module i2c_bit_ctrl
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          reset,
    i2c_bit_ctrl_if.slave bus
);

    state_e     state, state_n;
    phase_t     phase, phase_n;
    cmd_e       cmd_r, cmd_sel;
    logic       din_r, din_sel;
    logic       scl_s, sda_s;
    logic       accept, stretch, arb, adv, last;
    logic [1:0] drv;
    logic       scl_n, sda_n, done_n, arb_n, dout_n;

    i2c_sync #(.N(SYNC_STAGES)) u_scl_sync (.clk_i(clk_i), .reset(reset), .d(bus.scl_i), .q(scl_s));
    i2c_sync #(.N(SYNC_STAGES)) u_sda_sync (.clk_i(clk_i), .reset(reset), .d(bus.sda_i), .q(sda_s));

    assign accept  = bus.cmd_valid && state == IDLE;
    // A released SCL still read low means a slave is stretching the clock.
    assign stretch = !bus.scl_oe && !scl_s;
    assign arb     = state == RUN && cmd_r == CMD_WRITE && din_r && (phase == P1 || phase == P2) && !sda_s;
    assign adv     = state == RUN && bus.tick_i && !stretch && !arb;
    assign last    = adv && phase == P3;

    assign bus.cmd_ready = state == IDLE;
    assign bus.busy      = state == RUN;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= P0;
            cmd_r      <= CMD_START;
            din_r      <= 1'b0;
            bus.scl_oe <= 1'b0;
            bus.sda_oe <= 1'b0;
            bus.done   <= 1'b0;
            bus.arb_lost <= 1'b0;
            bus.dout   <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            cmd_r      <= cmd_sel;
            din_r      <= din_sel;
            bus.scl_oe <= scl_n;
            bus.sda_oe <= sda_n;
            bus.done   <= done_n;
            bus.arb_lost <= arb_n;
            bus.dout   <= dout_n;
        end
    end

    always_comb begin
        state_n = accept ? RUN : (arb || last) ? IDLE : state;
        phase_n = (accept || arb || last) ? P0 : adv ? phase + 1'b1 : phase;
    end

    // Line values are computed for the next phase so they appear registered
    // the cycle the phase begins; IDLE keeps the last P3 drive.
    always_comb begin
        cmd_sel = accept ? bus.cmd : cmd_r;
        din_sel = accept ? bus.cmd_din : din_r;
        drv     = line_drive(cmd_sel, phase_n, din_sel);
        {scl_n, sda_n} = arb ? 2'b00 : state_n == RUN ? drv : {bus.scl_oe, bus.sda_oe};
        done_n  = last;
        arb_n   = arb;
        dout_n  = (adv && phase == P2 && cmd_r == CMD_READ) ? sda_s : bus.dout;
    end

endmodule
